writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback result selection for the pipelined RISC-V core.
- Sole producer of the register file write port: RegWrite, Write_register, Write_data.
- Performs load byte/halfword extraction and sign/zero extension.
- Suppresses writes to x0 and to misaligned loads.
- Maintains a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, width of instret counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold stage contents
- flush  in  1  insert bubble; priority over stall
- in_valid  in  1  MEM stage holds a real instruction
- RegWrite_in  in  1  instruction writes rd
- rd_in  in  5  destination register
- ResultSrc  in  2  0=ALU, 1=load, 2=PC+4, 3=reserved (treated as ALU)
- funct3  in  3  load width code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ALUResult  in  XLEN  ALU result or load address
- ReadData  in  XLEN  aligned memory word containing load data
- PCPlus4  in  XLEN  link value
- RegWrite  out  1  register file write enable
- Write_register  out  5  register file write address
- Write_data  out  XLEN  register file write data
- wb_valid  out  1  stage holds a valid instruction
- load_misaligned  out  1  current load is misaligned
- instret  out  CNT_W  retired instruction count

Behaviour:
- Stage register fields: valid, regwrite, rd, resultsrc, funct3, alu, rdata, pc4.
- Posedge update, evaluated in priority order:
  - rst: valid=0, regwrite=0, rd=0, all data fields 0, instret=0.
  - flush: valid=0, regwrite=0; other fields don't-care; instret unchanged.
  - stall: all fields hold.
  - otherwise: capture all inputs; valid=in_valid, regwrite=RegWrite_in&in_valid.
- Outputs are combinational from the stage register only. Latency: captured at edge N, driven after N, register file writes at edge N+1.
- Reset values: RegWrite=0, Write_register=0, Write_data=0, wb_valid=0, load_misaligned=0, instret=0.
- Byte offset off = alu[1:0].
- Load extraction from rdata:
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign- or zero-extended.
  - LH/LHU: halfword at bits [16*off[1]+15 : 16*off[1]], sign- or zero-extended.
  - LW: full word.
  - Undefined funct3 is treated as LW.
- load_misaligned = valid & resultsrc==1 & ((LH/LHU & off[0]) | (LW & off!=0)).
- Write_data = mux(resultsrc): alu, extracted load, or pc4. Forced to 0 whenever RegWrite=0.
- RegWrite = valid & regwrite & (rd!=0) & ~load_misaligned.
- Write_register = rd when RegWrite=1, else 0.
- RegWrite stays asserted during stall. The repeated write is idempotent and is required for forwarding consistency.
- instret increments by 1 on a posedge where valid=1 & ~stall & ~flush & ~rst.
  - Misaligned loads and x0 writes still count as retired.
  - Wraps from all-ones to 0.
- Simultaneous stall and flush: flush wins and the stage becomes a bubble. An instruction stalled and then flushed is not counted.
- Reset mid-stall: stage cleared and counter zeroed on that edge.

Decomposition:
- Shared package core_pkg:
  - ResultSrc encodings RES_ALU, RES_LOAD, RES_PC4.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- One combinational sub-module, load_extend: inputs rdata, funct3, off; outputs extended value and misaligned flag. Reusable by the future store/LSU path.
- The stage register and counter stay in writeback_stage.

Test Plan:
- Reset then ALU op: capture rd=5, ALUResult=0x0000_1234, ResultSrc=0 -> next cycle RegWrite=1, Write_register=5, Write_data=0x1234, wb_valid=1; instret=1 after the following edge.
- Loads with ReadData=0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80
  - LBU off=3 -> 0x0000_0080
  - LH off=2 -> 0xFFFF_80FF
  - LHU off=0 -> 0x0000_7F01
  - LW off=0 -> 0x80FF_7F01
- Misaligned and x0:
  - LW with ALUResult=0x1002 -> load_misaligned=1, RegWrite=0, Write_data=0; instret still increments.
  - rd=0 with RegWrite_in=1 -> RegWrite=0.
- JAL link: ResultSrc=2, PCPlus4=0x0000_0104, rd=1 -> Write_data=0x104.
- Stall 3 cycles with a valid instruction -> outputs constant for 3 cycles, instret unchanged until release, then +1. Asserting stall and flush together -> wb_valid=0 next cycle, RegWrite=0, no count.
- Counter wrap: force-preload instret=0xFFFF_FFFF_FFFF_FFFF, retire one instruction -> instret=0. Assert rst mid-stream -> all outputs 0 after the edge.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the pipelined RISC-V core:
//   - XLEN          : datapath width
//   - RES_*         : ResultSrc encodings used by the writeback mux
//   - F3_*          : load funct3 width codes
//   - wb_stage_t    : contents of the MEM/WB pipeline register
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  // Writeback result selection. Encoding 3 is reserved and behaves like ALU.
  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_LOAD = 2'd1;
  localparam logic [1:0] RES_PC4  = 2'd2;

  // Load width codes (funct3). Any other code is handled as a word load.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic [4:0]      rd;
    logic [1:0]      resultsrc;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
  } wb_stage_t;

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load data extraction: selects the byte/halfword addressed by
// the low address bits out of an aligned memory word, sign- or zero-extends it,
// and flags misaligned halfword/word accesses.
// Ports:
//   rdata      in   aligned memory word
//   funct3     in   load width code (undefined codes act as LW)
//   off        in   byte offset within the word (address[1:0])
//   ext_data   out  extended load value
//   misaligned out  access is not naturally aligned for its width
// -----------------------------------------------------------------------------
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] ext_data,
  output logic            misaligned
);

  // Byte and halfword lanes of the 32-bit memory word.
  logic [7:0]  lane_byte [4];
  logic [15:0] lane_half [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign lane_byte[gi] = rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign lane_half[gi] = rdata[16*gi +: 16];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = lane_byte[off];
  assign sel_half = lane_half[off[1]];

  always_comb begin
    ext_data   = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  ext_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU: ext_data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH: begin
        ext_data   = {{(XLEN-16){sel_half[15]}}, sel_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        ext_data   = {{(XLEN-16){1'b0}}, sel_half};
        misaligned = off[0];
      end
      default: begin
        // LW and every undefined width code: whole word, must be word aligned.
        ext_data   = rdata;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// MEM/WB pipeline register plus writeback result selection. Sole driver of the
// register file write port. Also keeps the retired-instruction counter.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall, flush      hold the stage / turn it into a bubble (flush wins)
//   in_valid ...      MEM stage instruction fields captured each edge
//   RegWrite, Write_register, Write_data   register file write port
//   wb_valid          stage holds a valid instruction
//   load_misaligned   current load is misaligned (its write is suppressed)
//   instret           retired instruction count
// Outputs depend only on the stage register: an instruction captured at edge N
// drives the write port after N and is written into the register file at N+1.
// -----------------------------------------------------------------------------
module writeback_stage
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             RegWrite_in,
  input  logic [4:0]       rd_in,
  input  logic [1:0]       ResultSrc,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic [XLEN-1:0]  ReadData,
  input  logic [XLEN-1:0]  PCPlus4,
  output logic             RegWrite,
  output logic [4:0]       Write_register,
  output logic [XLEN-1:0]  Write_data,
  output logic             wb_valid,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] instret
);

  logic             valid_reg;
  logic             regwrite_reg;
  logic [4:0]       rd_reg;
  logic [1:0]       resultsrc_reg;
  logic [2:0]       funct3_reg;
  logic [XLEN-1:0]  alu_reg;
  logic [XLEN-1:0]  rdata_reg;
  logic [XLEN-1:0]  pc4_reg;
  logic [CNT_W-1:0] instret_reg;

  // ---------------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      rd_reg        <= '0;
      resultsrc_reg <= '0;
      funct3_reg    <= '0;
      alu_reg       <= '0;
      rdata_reg     <= '0;
      pc4_reg       <= '0;
    end else if (flush) begin
      // Data fields are left as they are; the bubble masks them.
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg     <= in_valid;
      regwrite_reg  <= RegWrite_in & in_valid;
      rd_reg        <= rd_in;
      resultsrc_reg <= ResultSrc;
      funct3_reg    <= funct3;
      alu_reg       <= ALUResult;
      rdata_reg     <= ReadData;
      pc4_reg       <= PCPlus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter. An instruction retires on the edge where it
  // leaves the stage normally; a stalled-then-flushed one never retires.
  // ---------------------------------------------------------------------------
  logic retire;
  assign retire = valid_reg & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (retire) begin
      instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] load_value;
  logic            load_misaligned_raw;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata      (rdata_reg),
    .funct3     (funct3_reg),
    .off        (alu_reg[1:0]),
    .ext_data   (load_value),
    .misaligned (load_misaligned_raw)
  );

  logic            is_load;
  logic            misaligned_now;
  logic            write_en;
  logic [XLEN-1:0] result;

  assign is_load        = (resultsrc_reg == RES_LOAD);
  assign misaligned_now = valid_reg & is_load & load_misaligned_raw;
  assign write_en       = valid_reg & regwrite_reg & (rd_reg != 5'd0) & ~misaligned_now;

  always_comb begin
    case (resultsrc_reg)
      RES_LOAD: result = load_value;
      RES_PC4:  result = pc4_reg;
      default:  result = alu_reg;   // RES_ALU and the reserved encoding
    endcase
  end

  // Write port is zeroed whenever no write happens so downstream forwarding
  // never sees stale data on an idle port.
  assign RegWrite        = write_en;
  assign Write_register  = write_en ? rd_reg : 5'd0;
  assign Write_data      = write_en ? result : '0;
  assign wb_valid        = valid_reg;
  assign load_misaligned = misaligned_now;
  assign instret         = instret_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed stimulus for writeback_stage with a behavioural reference model and
// literal expectations for the hand-computed cases.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [1:0]  ResultSrc = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUResult = '0;
  logic [31:0] ReadData = '0;
  logic [31:0] PCPlus4 = '0;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        wb_valid;
  logic        load_misaligned;
  logic [63:0] instret;

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .in_valid        (in_valid),
    .RegWrite_in     (RegWrite_in),
    .rd_in           (rd_in),
    .ResultSrc       (ResultSrc),
    .funct3          (funct3),
    .ALUResult       (ALUResult),
    .ReadData        (ReadData),
    .PCPlus4         (PCPlus4),
    .RegWrite        (RegWrite),
    .Write_register  (Write_register),
    .Write_data      (Write_data),
    .wb_valid        (wb_valid),
    .load_misaligned (load_misaligned),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the instruction currently sitting in writeback, plus a
  // plain retirement count. Outputs are derived with shifts and casts.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit          wr;
    bit [4:0]    rd;
    bit [1:0]    src;
    bit [2:0]    f3;
    bit [31:0]   alu;
    bit [31:0]   word;
    bit [31:0]   link;
  } instr_t;

  instr_t      m_cur;
  logic [63:0] m_count = '0;
  logic [63:0] m_tmp;
  bit          preload_req = 1'b0;
  bit          chk_en = 1'b0;

  initial begin
    m_cur = '{default: '0};
  end

  always @(posedge clk) begin
    m_tmp = preload_req ? 64'hFFFF_FFFF_FFFF_FFFF : m_count;
    if (rst) begin
      m_cur   = '{default: '0};
      m_count = '0;
    end else begin
      if (m_cur.valid && !stall && !flush) m_tmp = m_tmp + 64'd1;
      m_count = m_tmp;
      if (flush) begin
        m_cur.valid = 1'b0;
        m_cur.wr    = 1'b0;
      end else if (!stall) begin
        m_cur = '{valid: in_valid, wr: RegWrite_in && in_valid, rd: rd_in,
                  src: ResultSrc, f3: funct3, alu: ALUResult,
                  word: ReadData, link: PCPlus4};
      end
    end
  end

  function automatic bit m_misaligned(input instr_t i);
    int off;
    off = int'(i.alu % 4);
    if (!i.valid || i.src != 2'd1) return 1'b0;
    if (i.f3 == 3'd0 || i.f3 == 3'd4) return 1'b0;
    if (i.f3 == 3'd1 || i.f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] m_load(input instr_t i);
    int off;
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    off  = int'(i.alu % 4);
    b_sh = i.word >> (8 * off);
    h_sh = i.word >> (16 * (off / 2));
    sb   = b_sh[7:0];
    sh   = h_sh[15:0];
    case (i.f3)
      3'd0:    return 32'(sb);
      3'd4:    return b_sh & 32'h0000_00FF;
      3'd1:    return 32'(sh);
      3'd5:    return h_sh & 32'h0000_FFFF;
      default: return i.word;
    endcase
  endfunction

  function automatic bit m_we(input instr_t i);
    return i.valid && i.wr && (i.rd != 0) && !m_misaligned(i);
  endfunction

  function automatic logic [31:0] m_data(input instr_t i);
    if (!m_we(i)) return 32'd0;
    if (i.src == 2'd1) return m_load(i);
    if (i.src == 2'd2) return i.link;
    return i.alu;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.RegWrite", 64'(RegWrite), 64'(m_we(m_cur)));
      check("cyc.Write_register", 64'(Write_register), m_we(m_cur) ? 64'(m_cur.rd) : 64'd0);
      check("cyc.Write_data", 64'(Write_data), 64'(m_data(m_cur)));
      check("cyc.wb_valid", 64'(wb_valid), 64'(m_cur.valid));
      check("cyc.load_misaligned", 64'(load_misaligned), 64'(m_misaligned(m_cur)));
      check("cyc.instret", instret, m_count);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    in_valid    = v;
    RegWrite_in = rw;
    rd_in       = rd;
    ResultSrc   = src;
    funct3      = f3;
    ALUResult   = alu;
    ReadData    = rdata;
    PCPlus4     = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
    string       name;
  } load_vec_t;

  load_vec_t loads [6];

  initial begin
    loads[0] = '{3'b000, 2'd3, 32'hFFFF_FF80, "LB off3"};
    loads[1] = '{3'b100, 2'd3, 32'h0000_0080, "LBU off3"};
    loads[2] = '{3'b001, 2'd2, 32'hFFFF_80FF, "LH off2"};
    loads[3] = '{3'b101, 2'd0, 32'h0000_7F01, "LHU off0"};
    loads[4] = '{3'b010, 2'd0, 32'h80FF_7F01, "LW off0"};
    loads[5] = '{3'b000, 2'd1, 32'h0000_007F, "LB off1"};

    // Reset
    tick();
    tick();
    chk_en = 1'b1;
    check("rst.RegWrite", 64'(RegWrite), 64'd0);
    check("rst.Write_register", 64'(Write_register), 64'd0);
    check("rst.Write_data", 64'(Write_data), 64'd0);
    check("rst.wb_valid", 64'(wb_valid), 64'd0);
    check("rst.load_misaligned", 64'(load_misaligned), 64'd0);
    check("rst.instret", instret, 64'd0);
    rst = 1'b0;

    // ALU op
    drive(1, 1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    check("alu.RegWrite", 64'(RegWrite), 64'd1);
    check("alu.Write_register", 64'(Write_register), 64'd5);
    check("alu.Write_data", 64'(Write_data), 64'h1234);
    check("alu.wb_valid", 64'(wb_valid), 64'd1);
    check("alu.instret_before", instret, 64'd0);
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("alu.instret_after", instret, 64'd1);

    // Loads from 0x80FF_7F01, back to back
    foreach (loads[i]) begin
      drive(1, 1, 5'd10, 2'd1, loads[i].f3, 32'h0000_1000 | 32'(loads[i].off),
            32'h80FF_7F01, 32'h0);
      tick();
      check({"load.", loads[i].name}, 64'(Write_data), 64'(loads[i].exp));
      check({"load.we.", loads[i].name}, 64'(RegWrite), 64'd1);
    end

    // Misaligned LW
    drive(1, 1, 5'd11, 2'd1, 3'b010, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
    tick();
    check("mis.load_misaligned", 64'(load_misaligned), 64'd1);
    check("mis.RegWrite", 64'(RegWrite), 64'd0);
    check("mis.Write_data", 64'(Write_data), 64'd0);
    check("mis.instret_before", instret, 64'd7);

    // Write to x0
    drive(1, 1, 5'd0, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
    tick();
    check("mis.instret_after", instret, 64'd8);
    check("x0.RegWrite", 64'(RegWrite), 64'd0);
    check("x0.wb_valid", 64'(wb_valid), 64'd1);

    // JAL link
    drive(1, 1, 5'd1, 2'd2, 3'd0, 32'h0000_0999, 32'h0, 32'h0000_0104);
    tick();
    check("jal.Write_data", 64'(Write_data), 64'h104);
    check("jal.Write_register", 64'(Write_register), 64'd1);
    check("jal.instret", instret, 64'd9);

    // Stall three cycles with JAL held
    drive(1, 1, 5'd7, 2'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall.Write_data", 64'(Write_data), 64'h104);
      check("stall.RegWrite", 64'(RegWrite), 64'd1);
      check("stall.instret", instret, 64'd9);
    end
    stall = 1'b0;
    tick();
    check("release.instret", instret, 64'd10);
    check("release.Write_data", 64'(Write_data), 64'h77);

    // Stall and flush together
    stall = 1'b1;
    flush = 1'b1;
    drive(1, 1, 5'd8, 2'd0, 3'd0, 32'h0000_0088, 32'h0, 32'h0);
    tick();
    check("flush.wb_valid", 64'(wb_valid), 64'd0);
    check("flush.RegWrite", 64'(RegWrite), 64'd0);
    check("flush.instret", instret, 64'd10);
    stall = 1'b0;
    flush = 1'b0;
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("bubble.instret", instret, 64'd10);

    // Counter wrap: preload all-ones while the stage is empty
    #1;
    force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    preload_req = 1'b1;
    #1;
    release dut.instret_reg;
    drive(1, 1, 5'd3, 2'd0, 3'd0, 32'h0000_00AB, 32'h0, 32'h0);
    tick();
    preload_req = 1'b0;
    check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check("wrap.instret", instret, 64'd0);

    // Reset mid-stall
    drive(1, 1, 5'd4, 2'd0, 3'd0, 32'h0000_0044, 32'h0, 32'h0);
    tick();
    check("pre_rst.RegWrite", 64'(RegWrite), 64'd1);
    stall = 1'b1;
    rst   = 1'b1;
    tick();
    check("rst2.RegWrite", 64'(RegWrite), 64'd0);
    check("rst2.Write_register", 64'(Write_register), 64'd0);
    check("rst2.Write_data", 64'(Write_data), 64'd0);
    check("rst2.wb_valid", 64'(wb_valid), 64'd0);
    check("rst2.instret", instret, 64'd0);
    rst   = 1'b0;
    stall = 1'b0;
    drive(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
